// File: rtl/frv_fetch_queue.sv
// Halfword-granular fetch queue: takes aligned 32-bit fetch words, re-aligns mixed
// 16/32-bit instructions (including straddling ones) and hands one per cycle to decode.
module frv_fetch_queue #(
  parameter logic [31:0] FRV_PC_RESET_VALUE = 32'h8000_0000,
  parameter int          DEPTH              = 8,
  localparam int         CW                 = $clog2(DEPTH) + 1
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          flush,
  input  logic [31:0]   flush_pc,
  input  logic          f_valid,
  input  logic [31:0]   f_data,
  input  logic          f_error,
  output logic          f_ready,
  output logic          o_valid,
  input  logic          o_busy,
  output logic [31:0]   o_data,
  output logic [1:0]    o_size,
  output logic [31:0]   o_pc,
  output logic          o_error,
  output logic [CW-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);

  // Handshakes: a fetch word transfers when f_valid && f_ready && !flush; an
  // instruction transfers when o_valid && !o_busy && !flush. Flush wins over both.

  logic [16:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_nx;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nx;
  logic [CW-1:0] count_q, count_d;
  logic          drop_lo_q, drop_lo_d;
  logic [31:0]   pc_q, pc_d;

  logic [16:0]   h0, h1;
  logic          is32;
  logic          push, pop;
  logic [1:0]    push_n, pop_n;
  logic          unused_flush_lsb;

  assign unused_flush_lsb = flush_pc[0];

  assign rd_ptr_nx = rd_ptr_q + 1'b1;
  assign wr_ptr_nx = wr_ptr_q + 1'b1;
  assign h0        = mem_q[rd_ptr_q];
  assign h1        = mem_q[rd_ptr_nx];
  assign is32      = (h0[1:0] == 2'b11);

  // An errored head halfword always issues alone so decode sees the fault promptly.
  always_comb begin
    o_valid = 1'b0;
    o_size  = 2'b01;
    o_data  = {16'b0, h0[15:0]};
    o_error = 1'b0;
    if (h0[16]) begin
      o_valid = (count_q != '0);
      o_error = 1'b1;
    end else if (!is32) begin
      o_valid = (count_q != '0);
    end else begin
      o_valid = (count_q >= CW'(2));
      o_size  = 2'b10;
      o_data  = {h1[15:0], h0[15:0]};
      o_error = h1[16];
    end
  end

  assign f_ready = (count_q <= CW'(DEPTH - 2));
  assign push    = f_valid && f_ready && !flush;
  assign pop     = o_valid && !o_busy && !flush;
  assign push_n  = push ? (drop_lo_q ? 2'd1 : 2'd2) : 2'd0;
  assign pop_n   = pop ? (o_size[1] ? 2'd2 : 2'd1) : 2'd0;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    drop_lo_d = drop_lo_q;
    pc_d      = pc_q;
    if (flush) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      drop_lo_d = flush_pc[1];
      pc_d      = flush_pc;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop_n);
      wr_ptr_d = wr_ptr_q + PW'(push_n);
      count_d  = count_q + CW'(push_n) - CW'(pop_n);
      if (pop) pc_d = pc_q + (o_size[1] ? 32'd4 : 32'd2);
      if (push) drop_lo_d = 1'b0;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      drop_lo_q <= 1'b0;
      pc_q      <= FRV_PC_RESET_VALUE;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      drop_lo_q <= drop_lo_d;
      pc_q      <= pc_d;
    end
  end

  // With drop_lo set the word's low half precedes the jump target, so only the high half is kept.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      if (drop_lo_q) begin
        mem_q[wr_ptr_q] <= {f_error, f_data[31:16]};
      end else begin
        mem_q[wr_ptr_q]  <= {f_error, f_data[15:0]};
        mem_q[wr_ptr_nx] <= {f_error, f_data[31:16]};
      end
    end
  end

  assign o_pc    = pc_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_frv_fetch_queue.sv
// Self-checking bench for frv_fetch_queue: directed scenarios plus randomized traffic
// compared against a halfword-queue reference model.
module tb_frv_fetch_queue;

  localparam int DEPTH = 8;
  localparam int W     = 17;

  logic        g_clk;
  logic        g_resetn;
  logic        flush;
  logic [31:0] flush_pc;
  logic        f_valid;
  logic [31:0] f_data;
  logic        f_error;
  logic        f_ready;
  logic        o_valid;
  logic        o_busy;
  logic [31:0] o_data;
  logic [1:0]  o_size;
  logic [31:0] o_pc;
  logic        o_error;
  logic [3:0]  o_count;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {err, halfword}, the decode PC and the drop-low flag.
  logic [W-1:0] exp_q[$];
  logic [31:0]  exp_pc;
  logic         exp_drop;
  logic         exp_valid;
  logic [31:0]  exp_data;
  logic [1:0]   exp_size;
  logic         exp_err;

  frv_fetch_queue #(
    .FRV_PC_RESET_VALUE(32'h8000_0000),
    .DEPTH(DEPTH)
  ) dut (
    .g_clk(g_clk),
    .g_resetn(g_resetn),
    .flush(flush),
    .flush_pc(flush_pc),
    .f_valid(f_valid),
    .f_data(f_data),
    .f_error(f_error),
    .f_ready(f_ready),
    .o_valid(o_valid),
    .o_busy(o_busy),
    .o_data(o_data),
    .o_size(o_size),
    .o_pc(o_pc),
    .o_error(o_error),
    .o_count(o_count)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic model_reset();
    exp_q.delete();
    exp_pc   = 32'h8000_0000;
    exp_drop = 1'b0;
  endtask

  // What decode should see: an errored or compressed halfword issues alone; a 32-bit
  // opcode needs both halves present.
  task automatic model_head();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_size  = 2'b01;
    exp_err   = 1'b0;
    if (exp_q.size() >= 1) begin
      if (exp_q[0][16]) begin
        exp_valid = 1'b1;
        exp_data  = {16'b0, exp_q[0][15:0]};
        exp_err   = 1'b1;
      end else if (exp_q[0][1:0] != 2'b11) begin
        exp_valid = 1'b1;
        exp_data  = {16'b0, exp_q[0][15:0]};
      end else begin
        exp_size = 2'b10;
        if (exp_q.size() >= 2) begin
          exp_valid = 1'b1;
          exp_data  = {exp_q[1][15:0], exp_q[0][15:0]};
          exp_err   = exp_q[1][16];
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, leave time 1 after it.
  task automatic cycle(input logic fl, input logic [31:0] fpc, input logic fv,
                       input logic [31:0] fd, input logic fe, input logic busy);
    int n;
    flush    = fl;
    flush_pc = fpc;
    f_valid  = fv;
    f_data   = fd;
    f_error  = fe;
    o_busy   = busy;
    model_head();
    n = exp_q.size();
    if (fl) begin
      exp_q.delete();
      exp_pc   = fpc;
      exp_drop = fpc[1];
    end else begin
      if (exp_valid && !busy) begin
        if (exp_size == 2'b10) begin
          void'(exp_q.pop_front());
          void'(exp_q.pop_front());
          exp_pc = exp_pc + 32'd4;
        end else begin
          void'(exp_q.pop_front());
          exp_pc = exp_pc + 32'd2;
        end
      end
      if (fv && (DEPTH - n) >= 2) begin
        if (!exp_drop) exp_q.push_back({fe, fd[15:0]});
        exp_q.push_back({fe, fd[31:16]});
        exp_drop = 1'b0;
      end
    end
    @(posedge g_clk);
    #1;
    flush   = 1'b0;
    f_valid = 1'b0;
    model_head();
  endtask

  function automatic logic [15:0] rand_c16();
    logic [15:0] h;
    h      = 16'($urandom);
    h[1:0] = 2'($urandom_range(0, 2));
    return h;
  endfunction

  task automatic test_reset();
    g_resetn = 1'b0;
    flush = 0; flush_pc = 0; f_valid = 0; f_data = 0; f_error = 0; o_busy = 1;
    model_reset();
    repeat (2) @(posedge g_clk);
    #1;
    checks++;
    if ({o_valid, o_count, f_ready, o_pc, o_error} !== {1'b0, 4'd0, 1'b1, 32'h8000_0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_initial: valid=%0b count=%0d ready=%0b pc=%h err=%0b, want 0/0/1/80000000/0",
               o_valid, o_count, f_ready, o_pc, o_error);
    end
    g_resetn = 1'b1;
    @(posedge g_clk);
    #1;
    cycle(1, 32'h8000_0002, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, {rand_c16(), rand_c16()}, 0, 1);
    checks++;
    if (o_count !== 4'd5) begin
      errors++;
      $display("FAIL reset_prefill_count: got %0d want 5", o_count);
    end
    g_resetn = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({o_valid, o_count, f_ready, o_pc} !== {1'b0, 4'd0, 1'b1, 32'h8000_0000}) begin
      errors++;
      $display("FAIL reset_async: valid=%0b count=%0d ready=%0b pc=%h, want 0/0/1/80000000",
               o_valid, o_count, f_ready, o_pc);
    end
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    @(posedge g_clk);
    #1;
  endtask

  task automatic test_single32();
    cycle(0, 0, 1, 32'h00A0_0093, 0, 1);
    checks++;
    if ({o_valid, o_size, o_data, o_pc} !== {1'b1, 2'b10, 32'h00A0_0093, 32'h8000_0000}) begin
      errors++;
      $display("FAIL single32_head: valid=%0b size=%b data=%h pc=%h, want 1/10/00a00093/80000000",
               o_valid, o_size, o_data, o_pc);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if ({o_pc, o_count, o_valid} !== {32'h8000_0004, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL single32_pop: pc=%h count=%0d valid=%0b, want 80000004/0/0", o_pc, o_count, o_valid);
    end
  endtask

  task automatic test_two_compressed();
    cycle(1, 32'h8000_0000, 0, 0, 0, 1);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid_low: got %0b want 0", o_valid);
    end
    cycle(0, 0, 1, 32'h4085_0505, 0, 1);
    checks++;
    if ({o_valid, o_size, o_data, o_pc} !== {1'b1, 2'b01, 32'h0000_0505, 32'h8000_0000}) begin
      errors++;
      $display("FAIL c16_first: valid=%0b size=%b data=%h pc=%h, want 1/01/00000505/80000000",
               o_valid, o_size, o_data, o_pc);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if ({o_valid, o_size, o_data, o_pc} !== {1'b1, 2'b01, 32'h0000_4085, 32'h8000_0002}) begin
      errors++;
      $display("FAIL c16_second: valid=%0b size=%b data=%h pc=%h, want 1/01/00004085/80000002",
               o_valid, o_size, o_data, o_pc);
    end
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_straddle();
    cycle(1, 32'h8000_0000, 0, 0, 0, 1);
    cycle(0, 0, 1, 32'h0093_0001, 0, 1);
    checks++;
    if ({o_valid, o_size, o_data, o_pc} !== {1'b1, 2'b01, 32'h0000_0001, 32'h8000_0000}) begin
      errors++;
      $display("FAIL straddle_c16: valid=%0b size=%b data=%h pc=%h, want 1/01/00000001/80000000",
               o_valid, o_size, o_data, o_pc);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if ({o_valid, o_count} !== {1'b0, 4'd1}) begin
      errors++;
      $display("FAIL straddle_partial: valid=%0b count=%0d, want 0/1", o_valid, o_count);
    end
    cycle(0, 0, 1, 32'h0000_00A0, 0, 1);
    checks++;
    if ({o_valid, o_size, o_data, o_pc, o_error} !== {1'b1, 2'b10, 32'h00A0_0093, 32'h8000_0002, 1'b0}) begin
      errors++;
      $display("FAIL straddle_32: valid=%0b size=%b data=%h pc=%h err=%0b, want 1/10/00a00093/80000002/0",
               o_valid, o_size, o_data, o_pc, o_error);
    end
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flush();
    cycle(1, 32'h8000_0002, 0, 0, 0, 1);
    cycle(0, 0, 1, {rand_c16(), rand_c16()}, 0, 1);
    cycle(0, 0, 1, {rand_c16(), rand_c16()}, 0, 1);
    checks++;
    if (o_count !== 4'd3) begin
      errors++;
      $display("FAIL flush_prefill: count=%0d want 3", o_count);
    end
    cycle(1, 32'h8000_0102, 1, 32'hDEAD_BEEF, 0, 0);
    checks++;
    if ({o_count, o_valid, o_pc} !== {4'd0, 1'b0, 32'h8000_0102}) begin
      errors++;
      $display("FAIL flush_clear: count=%0d valid=%0b pc=%h, want 0/0/80000102", o_count, o_valid, o_pc);
    end
    cycle(0, 0, 1, 32'h0001_ABCD, 0, 1);
    checks++;
    if ({o_count, o_valid, o_size, o_data, o_pc} !== {4'd1, 1'b1, 2'b01, 32'h0000_0001, 32'h8000_0102}) begin
      errors++;
      $display("FAIL flush_unaligned: count=%0d valid=%0b size=%b data=%h pc=%h, want 1/1/01/00000001/80000102",
               o_count, o_valid, o_size, o_data, o_pc);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if ({o_count, o_valid, o_pc} !== {4'd0, 1'b0, 32'h8000_0104}) begin
      errors++;
      $display("FAIL flush_drain: count=%0d valid=%0b pc=%h, want 0/0/80000104", o_count, o_valid, o_pc);
    end
  endtask

  task automatic test_backpressure();
    cycle(1, 32'h8000_0000, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, {rand_c16(), rand_c16()}, 0, 1);
    checks++;
    if ({o_count, f_ready} !== {4'd8, 1'b0}) begin
      errors++;
      $display("FAIL full: count=%0d ready=%0b, want 8/0", o_count, f_ready);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({o_valid, o_size, o_data, o_pc} !== {exp_valid, exp_size, exp_data, 32'h8000_0000 + 32'(2 * i)}) begin
        errors++;
        $display("FAIL drain_%0d: valid=%0b size=%b data=%h pc=%h, want %0b/%b/%h/%h", i,
                 o_valid, o_size, o_data, o_pc, exp_valid, exp_size, exp_data, 32'h8000_0000 + 32'(2 * i));
      end
      cycle(0, 0, 0, 0, 0, 0);
    end
    checks++;
    if ({o_count, o_valid, f_ready} !== {4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL drained: count=%0d valid=%0b ready=%0b, want 0/0/1", o_count, o_valid, f_ready);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, {rand_c16(), rand_c16()}, 0, 1);
    cycle(0, 0, 1, 32'h1234_0003, 1, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if ({o_valid, o_size, o_data, o_error, o_pc} !== {1'b1, 2'b01, 32'h0000_0003, 1'b1, 32'h8000_001C}) begin
      errors++;
      $display("FAIL err_head: valid=%0b size=%b data=%h err=%0b pc=%h, want 1/01/00000003/1/8000001c",
               o_valid, o_size, o_data, o_error, o_pc);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if ({o_valid, o_size, o_data, o_error, o_count} !== {1'b1, 2'b01, 32'h0000_1234, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL err_second: valid=%0b size=%b data=%h err=%0b count=%0d, want 1/01/00001234/1/1",
               o_valid, o_size, o_data, o_error, o_count);
    end
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [15:0] lo, hi;
    for (int i = 0; i < 600; i++) begin
      checks++;
      if ({o_valid, o_count, f_ready, o_pc} !== {exp_valid, 4'(exp_q.size()), (DEPTH - exp_q.size()) >= 2, exp_pc}) begin
        errors++;
        $display("FAIL rand_state_%0d: valid=%0b count=%0d ready=%0b pc=%h, want %0b/%0d/%0b/%h", i,
                 o_valid, o_count, f_ready, o_pc, exp_valid, exp_q.size(), (DEPTH - exp_q.size()) >= 2, exp_pc);
      end
      if (exp_valid) begin
        checks++;
        if ({o_data, o_size, o_error} !== {exp_data, exp_size, exp_err}) begin
          errors++;
          $display("FAIL rand_head_%0d: data=%h size=%b err=%0b, want %h/%b/%0b", i,
                   o_data, o_size, o_error, exp_data, exp_size, exp_err);
        end
      end
      lo = ($urandom_range(0, 1) == 0) ? rand_c16() : {16'($urandom) | 16'h0003};
      hi = ($urandom_range(0, 1) == 0) ? rand_c16() : {16'($urandom) | 16'h0003};
      cycle($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 2) != 0, {hi, lo},
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_single32();
    test_two_compressed();
    test_straddle();
    test_flush();
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frv_fetch_queue.md
Name: frv_fetch_queue

Overview:
- Parametrised halfword-granular instruction fetch queue. Sits between the fetch stage and decode in the front-end pipeline.
- Accepts aligned 32-bit fetch words and re-aligns mixed 16/32-bit instructions, including 32-bit instructions that straddle two fetch words. Tracks the decode-aligned PC.
- Presents one whole instruction per cycle to decode using the core's valid/busy handshake.
- Replaces the fixed single-word fetch-to-decode path with configurable buffering depth and unaligned control-flow targets.

Parameters:
FRV_PC_RESET_VALUE, 32'h8000_0000, value o_pc takes on reset.
DEPTH, 8, queue capacity in halfword entries; power of 2, >= 4.
CW, $clog2(DEPTH)+1, width of occupancy count (derived, localparam).

Ports:
g_clk      input   1   global clock
g_resetn   input   1   reset, asynchronous, active-low
flush      input   1   control-flow change accepted this cycle
flush_pc   input   32  new PC on flush
f_valid    input   1   fetch word valid
f_data     input   32  fetch word (from aligned address)
f_error    input   1   fetch word suffered an ifetch error
f_ready    output  1   queue can accept a fetch word this cycle
o_valid    output  1   complete instruction at head
o_busy     input   1   decode busy; instruction not consumed
o_data     output  32  instruction; upper 16 bits zero for 16-bit
o_size     output  2   one-hot: 2'b01 = 16-bit, 2'b10 = 32-bit
o_pc       output  32  PC of head instruction
o_error    output  1   head instruction tainted by fetch error
o_count    output  CW  occupancy in halfwords

Behaviour:
- Reset is asynchronous and active-low. While asserted and after release:
  - count = 0; read/write pointers = 0; drop_lo = 0.
  - o_pc = FRV_PC_RESET_VALUE; o_valid = 0; o_error = 0; f_ready = 1.
- Storage: DEPTH entries, each {err, hw[15:0]}. Pointers wrap modulo DEPTH.
- Push:
  - Push occurs when f_valid && f_ready && !flush.
  - Writes f_data[15:0] then f_data[31:16], each tagged with f_error. Count += 2.
  - If drop_lo = 1: the low half is discarded, only f_data[31:16] is written, count += 1, and drop_lo clears.
- f_ready = (DEPTH - count) >= 2. Computed from registered count only; it does not anticipate a same-cycle pop.
- f_valid while !f_ready: word is ignored (the source is required not to do this).
- Head decode (combinational from registered state):
  - Let h0 = head entry, h1 = next entry.
  - is32 = (h0.hw[1:0] == 2'b11).
  - Error case: if h0.err, then o_valid = (count >= 1), o_size = 01, o_data = {16'b0, h0.hw}, o_error = 1.
  - 16-bit case (!is32): o_valid = (count >= 1), o_size = 01, o_data = {16'b0, h0.hw}, o_error = 0.
  - 32-bit case (is32): o_valid = (count >= 2), o_size = 10, o_data = {h1.hw, h0.hw}, o_error = h1.err.
- Pop:
  - Pop occurs when o_valid && !o_busy && !flush.
  - Read pointer advances 1 or 2 entries; count decrements accordingly.
  - o_pc += 2 (size 01) or 4 (size 10), modulo 2^32.
- Simultaneous push and pop: count_next = count + pushed - popped. Full and empty boundaries stay exact.
- Flush has priority over push and pop in the same cycle:
  - count, pointers cleared; o_pc <= flush_pc.
  - drop_lo <= flush_pc[1]. flush_pc[0] is ignored.
  - Same-cycle f_valid word is discarded.
  - o_valid = 0 the cycle after flush.
- Latency: a word pushed in cycle N is visible at the head in cycle N+1. No combinational path from f_* to o_*.
- Outputs are stable while o_valid && o_busy.
- A partial 32-bit instruction (count == 1, is32) holds o_valid = 0 until the next push completes it.

Test Plan:
- Reset: hold g_resetn = 0 mid-operation with count = 5 → immediately o_valid = 0, o_count = 0, o_pc = 0x8000_0000, f_ready = 1.
- Single 32-bit: push 0x00A00093 → next cycle o_valid = 1, o_size = 10, o_data = 0x00A00093, o_pc = 0x8000_0000; pop → o_pc = 0x8000_0004, o_count = 0.
- Two compressed: push 0x40850505 → o_data = 0x0505 at PC 0x8000_0000, then 0x4085 at PC 0x8000_0002, size 01 both.
- Straddling instruction:
  - Push 0x00930001 → 0x0001 issued at 0x8000_0000.
  - Then o_valid = 0 while only 0x0093 is queued.
  - Push 0x000000A0 → o_data = 0x00A00093, o_size = 10, o_pc = 0x8000_0002.
- Flush with unaligned target:
  - With 3 entries queued, flush = 1, flush_pc = 0x8000_0102, and f_valid = 1 in the same cycle → count = 0, the same-cycle word is discarded.
  - Next push 0x0001ABCD → only 0x0001 is issued, at o_pc = 0x8000_0102.
- Backpressure, wrap and error:
  - DEPTH = 8, o_busy = 1, push 4 words of compressed pairs → o_count = 8, f_ready = 0.
  - Release o_busy → 8 instructions drain in order.
  - Refill across the pointer wrap; a word with f_error = 1 issues o_error = 1 with size 01.
